// File: rtl/ibex_pkg.sv
// Shared constants and RV32 base opcodes used by the fetch realigner and the
// compressed-instruction expander.
package ibex_pkg;

    localparam int unsigned HalfwordBits  = 16;
    localparam int unsigned WordBits      = 32;
    localparam int unsigned HalfwordBytes = 2;
    localparam int unsigned WordBytes     = 4;

    typedef enum logic [6:0] {
        OPCODE_LOAD   = 7'h03,
        OPCODE_OP_IMM = 7'h13,
        OPCODE_STORE  = 7'h23,
        OPCODE_OP     = 7'h33,
        OPCODE_LUI    = 7'h37,
        OPCODE_BRANCH = 7'h63,
        OPCODE_JALR   = 7'h67,
        OPCODE_JAL    = 7'h6f,
        OPCODE_SYSTEM = 7'h73
    } opcode_e;

endpackage

// File: rtl/ibex_c_expand.sv
// Combinational RV32C -> RV32I expander. A halfword with [1:0]==2'b11 is not
// compressed and is passed through unflagged; with RVC disabled every
// compressed-looking halfword is passed raw and flagged illegal.
module ibex_c_expand
    import ibex_pkg::*;
(
    input  logic [15:0] instr_i,
    input  logic        rvc_en_i,
    output logic [31:0] instr_o,
    output logic        illegal_o
);

    always_comb begin
        instr_o   = {16'h0, instr_i};
        illegal_o = 1'b0;
        if (!rvc_en_i) begin
            illegal_o = (instr_i[1:0] != 2'b11);
        end else begin
            case (instr_i[1:0])
                2'b00: begin
                    case (instr_i[15:13])
                        3'b000: begin
                            instr_o = {2'b00, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6],
                                       2'b00, 5'h02, 3'b000, 2'b01, instr_i[4:2], OPCODE_OP_IMM};
                            illegal_o = (instr_i[12:5] == 8'h00);
                        end
                        3'b010: instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00,
                                           2'b01, instr_i[9:7], 3'b010, 2'b01, instr_i[4:2], OPCODE_LOAD};
                        3'b110: instr_o = {5'b0, instr_i[5], instr_i[12], 2'b01, instr_i[4:2],
                                           2'b01, instr_i[9:7], 3'b010, instr_i[11:10], instr_i[6],
                                           2'b00, OPCODE_STORE};
                        default: illegal_o = 1'b1;
                    endcase
                end
                2'b01: begin
                    case (instr_i[15:13])
                        3'b000: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], instr_i[11:7],
                                           3'b000, instr_i[11:7], OPCODE_OP_IMM};
                        3'b001, 3'b101: instr_o = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6],
                                                   instr_i[7], instr_i[2], instr_i[11], instr_i[5:3],
                                                   {9{instr_i[12]}}, 4'b0, ~instr_i[15], OPCODE_JAL};
                        3'b010: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 5'b0,
                                           3'b000, instr_i[11:7], OPCODE_OP_IMM};
                        3'b011: begin
                            if (instr_i[11:7] == 5'd2) begin
                                instr_o = {{3{instr_i[12]}}, instr_i[4:3], instr_i[5], instr_i[2],
                                           instr_i[6], 4'b0, 5'h02, 3'b000, 5'h02, OPCODE_OP_IMM};
                            end else begin
                                instr_o = {{15{instr_i[12]}}, instr_i[6:2], instr_i[11:7], OPCODE_LUI};
                            end
                            illegal_o = ({instr_i[12], instr_i[6:2]} == 6'b0);
                        end
                        3'b100: begin
                            case (instr_i[11:10])
                                2'b00, 2'b01: begin
                                    // srli/srai: shamt[5] must be zero on RV32
                                    instr_o = {1'b0, instr_i[10], 5'b0, instr_i[6:2], 2'b01, instr_i[9:7],
                                               3'b101, 2'b01, instr_i[9:7], OPCODE_OP_IMM};
                                    illegal_o = instr_i[12];
                                end
                                2'b10: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 2'b01,
                                                  instr_i[9:7], 3'b111, 2'b01, instr_i[9:7], OPCODE_OP_IMM};
                                default: begin
                                    if (instr_i[12]) begin
                                        illegal_o = 1'b1;
                                    end else begin
                                        case (instr_i[6:5])
                                            2'b00: instr_o = {2'b01, 5'b0, 2'b01, instr_i[4:2], 2'b01,
                                                              instr_i[9:7], 3'b000, 2'b01, instr_i[9:7], OPCODE_OP};
                                            2'b01: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01,
                                                              instr_i[9:7], 3'b100, 2'b01, instr_i[9:7], OPCODE_OP};
                                            2'b10: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01,
                                                              instr_i[9:7], 3'b110, 2'b01, instr_i[9:7], OPCODE_OP};
                                            default: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01,
                                                                instr_i[9:7], 3'b111, 2'b01, instr_i[9:7], OPCODE_OP};
                                        endcase
                                    end
                                end
                            endcase
                        end
                        default: instr_o = {{4{instr_i[12]}}, instr_i[6:5], instr_i[2], 5'b0, 2'b01,
                                            instr_i[9:7], 2'b00, instr_i[13], instr_i[11:10],
                                            instr_i[4:3], instr_i[12], OPCODE_BRANCH};
                    endcase
                end
                2'b10: begin
                    case (instr_i[15:13])
                        3'b000: begin
                            instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b001, instr_i[11:7], OPCODE_OP_IMM};
                            illegal_o = instr_i[12];
                        end
                        3'b010: begin
                            instr_o = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00, 5'h02,
                                       3'b010, instr_i[11:7], OPCODE_LOAD};
                            illegal_o = (instr_i[11:7] == 5'd0);
                        end
                        3'b100: begin
                            if (!instr_i[12]) begin
                                if (instr_i[6:2] != 5'd0) begin
                                    instr_o = {7'b0, instr_i[6:2], 5'b0, 3'b000, instr_i[11:7], OPCODE_OP};
                                end else begin
                                    instr_o = {12'b0, instr_i[11:7], 3'b000, 5'b0, OPCODE_JALR};
                                    illegal_o = (instr_i[11:7] == 5'd0);
                                end
                            end else if (instr_i[6:2] != 5'd0) begin
                                instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b000, instr_i[11:7], OPCODE_OP};
                            end else if (instr_i[11:7] == 5'd0) begin
                                instr_o = {12'h001, 5'b0, 3'b000, 5'b0, OPCODE_SYSTEM};
                            end else begin
                                instr_o = {12'b0, instr_i[11:7], 3'b000, 5'b00001, OPCODE_JALR};
                            end
                        end
                        3'b110: instr_o = {4'b0, instr_i[8:7], instr_i[12], instr_i[6:2], 5'h02,
                                           3'b010, instr_i[11:9], 2'b00, OPCODE_STORE};
                        default: illegal_o = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ibex_instr_realigner.sv
// Fetch-word realigner: buffers aligned 32-bit words, extracts 16/32-bit
// instructions (including word-straddling ones), expands RVC and tracks PC.
module ibex_instr_realigner
    import ibex_pkg::*;
#(
    parameter int unsigned Depth     = 2,
    parameter bit          RVCEnable = 1'b1,
    parameter logic [31:0] ResetPc   = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_instr_raw_o,
    output logic        out_is_compressed_o,
    output logic        out_illegal_o,
    output logic        out_err_o,
    output logic [31:0] out_pc_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [WordBits-1:0] data_q [Depth];
    logic                err_q  [Depth];
    logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q, nxt_ptr;
    logic [CntW-1:0]     count_q, count_d;
    logic                off_q, off_d;
    logic [31:0]         pc_q, pc_d;

    logic [31:0] head_data;
    logic        head_err, next_err;
    logic [15:0] next_lo, lo;
    logic        lo_is_c, cand_valid, push, pop, fire;
    logic [31:0] exp_instr;
    logic        exp_illegal;
    logic        unused_addr0;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_addr0 = flush_addr_i[0];

    assign nxt_ptr   = ptr_inc(rd_ptr_q);
    assign head_data = data_q[rd_ptr_q];
    assign head_err  = err_q[rd_ptr_q];
    assign next_lo   = data_q[nxt_ptr][15:0];
    assign next_err  = err_q[nxt_ptr];

    assign lo      = off_q ? head_data[31:16] : head_data[15:0];
    assign lo_is_c = (lo[1:0] != 2'b11);

    // An erroneous head is reported immediately; only a clean straddling
    // instruction has to wait for the following word.
    assign cand_valid = (count_q != '0) &&
                        (head_err || lo_is_c || !off_q || (count_q >= CntW'(2)));

    assign out_valid_o = cand_valid && !flush_i;
    assign in_ready_o  = (count_q < CntW'(Depth)) && !flush_i;
    assign out_pc_o    = pc_q;

    assign push = in_valid_i && in_ready_o;
    assign fire = out_valid_o && out_ready_i;

    ibex_c_expand u_c_expand (
        .instr_i  (lo),
        .rvc_en_i (RVCEnable),
        .instr_o  (exp_instr),
        .illegal_o(exp_illegal)
    );

    always_comb begin
        out_instr_o         = '0;
        out_instr_raw_o     = '0;
        out_is_compressed_o = 1'b0;
        out_illegal_o       = 1'b0;
        out_err_o           = 1'b0;
        if (cand_valid) begin
            if (head_err) begin
                out_err_o = 1'b1;
            end else if (lo_is_c) begin
                out_instr_o         = exp_instr;
                out_instr_raw_o     = {16'h0, lo};
                out_is_compressed_o = 1'b1;
                out_illegal_o       = exp_illegal;
            end else begin
                out_instr_o     = off_q ? {next_lo, lo} : head_data;
                out_instr_raw_o = off_q ? {next_lo, lo} : head_data;
                out_err_o       = off_q && next_err;
            end
        end
    end

    always_comb begin
        pop   = 1'b0;
        off_d = off_q;
        pc_d  = pc_q;
        if (fire) begin
            pc_d = pc_q + (out_is_compressed_o ? 32'(HalfwordBytes) : 32'(WordBytes));
            if (head_err) begin
                pop   = 1'b1;
                off_d = 1'b0;
            end else if (lo_is_c) begin
                pop   = off_q;
                off_d = !off_q;
            end else begin
                // A straddling instruction leaves off=1 pointing into the next word
                pop = 1'b1;
            end
        end
    end

    assign count_d = count_q + CntW'(push) - CntW'(pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            off_q    <= 1'b0;
            pc_q     <= ResetPc;
        end else if (flush_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            off_q    <= flush_addr_i[1];
            pc_q     <= {flush_addr_i[31:1], 1'b0};
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= nxt_ptr;
            count_q <= count_d;
            off_q   <= off_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_ptr_q] <= in_rdata_i;
            err_q[wr_ptr_q]  <= in_err_i;
        end
    end

endmodule

// File: tb/tb_ibex_instr_realigner.sv
// Directed and randomized bench for ibex_instr_realigner against a
// halfword-stream scoreboard built from instruction-field encoders.
module tb_ibex_instr_realigner;

    localparam int unsigned Depth = 2;
    localparam logic [31:0] RstPc = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_err, out_valid, out_ready;
    logic [31:0] flush_addr, in_rdata, out_instr, out_raw, out_pc;
    logic        out_comp, out_ill, out_err;
    int          total = 0;
    int          bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] raw;
        logic        comp;
        logic        ill;
        logic [31:0] pc;
        int          h;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] hw_q[$];
    logic [31:0] words[$];

    always #5 clk = ~clk;

    ibex_instr_realigner #(
        .Depth    (Depth),
        .RVCEnable(1'b1),
        .ResetPc  (RstPc)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .flush_i            (flush),
        .flush_addr_i       (flush_addr),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_rdata_i         (in_rdata),
        .in_err_i           (in_err),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .out_instr_o        (out_instr),
        .out_instr_raw_o    (out_raw),
        .out_is_compressed_o(out_comp),
        .out_illegal_o      (out_ill),
        .out_err_o          (out_err),
        .out_pc_o           (out_pc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_flush(input logic [31:0] a);
        flush      = 1'b1;
        flush_addr = a;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic push(input logic [31:0] w, input logic e);
        in_valid = 1'b1;
        in_rdata = w;
        in_err   = e;
        #1;
        chk("push_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_err   = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] instr, input logic [31:0] raw,
                              input logic [31:0] pc, input logic comp, input logic ill,
                              input logic err, input bit check_instr);
        out_ready = 1'b1;
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        if (check_instr) chk({tag, "_instr"}, out_instr, instr);
        chk({tag, "_raw"}, out_raw, raw);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_comp"}, out_comp, comp);
        chk({tag, "_ill"}, out_ill, ill);
        chk({tag, "_err"}, out_err, err);
        $display("txn %s pc=%h instr=%h raw=%h c=%0d ill=%0d err=%0d",
                 tag, out_pc, out_instr, out_raw, out_comp, out_ill, out_err);
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [4:0]  rd, rs2, uimm;
        logic [5:0]  imm6;
        logic [2:0]  rdp, rsp;
        logic [31:0] w32, base;
        logic [15:0] c;
        exp_t        ex;
        int          start_off, kind, h_next, pushed, held, e, cyc;
        bit          exp_valid;

        rst_n = 1'b0; flush = 1'b0; flush_addr = '0; in_valid = 1'b0;
        in_rdata = '0; in_err = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_pc", out_pc, RstPc);
        chk("rst_instr", out_instr, 0);
        chk("rst_err", out_err, 0);

        // aligned 32-bit
        do_flush(32'h100);
        push(32'h00A00513, 1'b0);
        expect_pop("aligned", 32'h00A00513, 32'h00A00513, 32'h100, 0, 0, 0, 1);
        #1 chk("aligned_empty", out_valid, 0);

        // two compressed in one word; pop only after the second
        do_flush(32'h100);
        push(32'h45050001, 1'b0);
        expect_pop("c_nop", 32'h00000013, 32'h00000001, 32'h100, 1, 0, 0, 1);
        expect_pop("c_li", 32'h00100513, 32'h00004505, 32'h102, 1, 0, 0, 1);
        #1 chk("c_pair_empty", out_valid, 0);

        // straddle
        do_flush(32'h102);
        push(32'h05130000, 1'b0);
        chk("straddle_wait", out_valid, 0);
        push(32'h000100A0, 1'b0);
        expect_pop("straddle", 32'h00A00513, 32'h00A00513, 32'h102, 0, 0, 0, 1);
        expect_pop("after_straddle", 32'h00000013, 32'h00000001, 32'h106, 1, 0, 0, 1);

        // illegal zero halfwords, then a bus error
        do_flush(32'h100);
        push(32'h00000000, 1'b0);
        expect_pop("ill_lo", 32'h0, 32'h0, 32'h100, 1, 1, 0, 0);
        expect_pop("ill_hi", 32'h0, 32'h0, 32'h102, 1, 1, 0, 0);
        do_flush(32'h200);
        push(32'hDEADBEEF, 1'b1);
        expect_pop("bus_err", 32'h0, 32'h0, 32'h200, 0, 0, 1, 1);
        #1 chk("bus_err_empty", out_valid, 0);

        // backpressure / full buffer
        do_flush(32'h100);
        in_valid = 1'b1;
        in_rdata = 32'h00A00513; tick();
        in_rdata = 32'h00B00593; tick();
        in_rdata = 32'h00C00613;
        #1;
        chk("full_ready", in_ready, 0);
        chk("full_instr", out_instr, 32'h00A00513);
        tick();
        in_valid = 1'b0;
        #1;
        chk("hold_valid", out_valid, 1);
        chk("hold_instr", out_instr, 32'h00A00513);
        chk("hold_pc", out_pc, 32'h100);
        expect_pop("drain_a", 32'h00A00513, 32'h00A00513, 32'h100, 0, 0, 0, 1);
        expect_pop("drain_b", 32'h00B00593, 32'h00B00593, 32'h104, 0, 0, 0, 1);
        #1 chk("drain_empty", out_valid, 0);

        // flush beats simultaneous push and pop
        do_flush(32'h100);
        push(32'h00A00513, 1'b0);
        in_valid = 1'b1; in_rdata = 32'h00B00593; out_ready = 1'b1;
        flush = 1'b1; flush_addr = 32'h301;
        #1;
        chk("flush_cycle_valid", out_valid, 0);
        chk("flush_cycle_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_pc", out_pc, 32'h300);
        push(32'h00D00693, 1'b0);
        expect_pop("post_flush", 32'h00D00693, 32'h00D00693, 32'h300, 0, 0, 0, 1);

        // reset with a full buffer
        do_flush(32'h100);
        push(32'h00A00513, 1'b0);
        push(32'h00B00593, 1'b0);
        #1 chk("pre_rst_ready", in_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst2_valid", out_valid, 0);
        chk("rst2_ready", in_ready, 1);
        chk("rst2_pc", out_pc, RstPc);

        // randomized stream against halfword scoreboard
        start_off = $urandom_range(0, 1);
        base = 32'h0000_4000;
        if (start_off != 0) hw_q.push_back(16'($urandom));
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 7);
            rd   = 5'($urandom_range(1, 31));
            rs2  = 5'($urandom_range(1, 31));
            imm6 = 6'($urandom);
            rdp  = 3'($urandom);
            rsp  = 3'($urandom);
            uimm = 5'($urandom);
            if (kind == 2 && imm6 == 6'd0) imm6 = 6'd1;
            ex.ill = 1'b0;
            ex.comp = 1'b1;
            ex.h = hw_q.size();
            ex.pc = base + 32'(2 * ex.h);
            c = 16'h0001;
            ex.instr = 32'h13;
            case (kind)
                0: begin
                    w32 = $urandom;
                    w32[1:0] = 2'b11;
                    ex.comp = 1'b0;
                    ex.instr = w32;
                end
                1: begin
                    c = {3'b010, imm6[5], rd, imm6[4:0], 2'b01};
                    ex.instr = {{6{imm6[5]}}, imm6, 5'd0, 3'd0, rd, 7'h13};
                end
                2: begin
                    c = {3'b000, imm6[5], rd, imm6[4:0], 2'b01};
                    ex.instr = {{6{imm6[5]}}, imm6, rd, 3'd0, rd, 7'h13};
                end
                3: begin
                    c = {4'b1000, rd, rs2, 2'b10};
                    ex.instr = {7'd0, rs2, 5'd0, 3'd0, rd, 7'h33};
                end
                4: begin
                    c = {4'b1001, rd, rs2, 2'b10};
                    ex.instr = {7'd0, rs2, rd, 3'd0, rd, 7'h33};
                end
                5: begin
                    c = {3'b010, uimm[3:1], rsp, uimm[0], uimm[4], rdp, 2'b00};
                    ex.instr = {5'd0, uimm, 2'b00, 2'b01, rsp, 3'b010, 2'b01, rdp, 7'h03};
                end
                6: c = 16'h0001;
                default: begin
                    c = 16'h0000;
                    ex.ill = 1'b1;
                end
            endcase
            if (ex.comp) begin
                ex.raw = {16'h0, c};
                hw_q.push_back(c);
            end else begin
                ex.raw = ex.instr;
                hw_q.push_back(ex.instr[15:0]);
                hw_q.push_back(ex.instr[31:16]);
            end
            exp_q.push_back(ex);
        end
        if (hw_q.size() % 2 != 0) begin
            ex.instr = 32'h13; ex.raw = 32'h1; ex.comp = 1'b1; ex.ill = 1'b0;
            ex.h = hw_q.size(); ex.pc = base + 32'(2 * ex.h);
            hw_q.push_back(16'h0001);
            exp_q.push_back(ex);
        end
        for (int k = 0; k < hw_q.size() / 2; k++) words.push_back({hw_q[2*k+1], hw_q[2*k]});

        do_flush(base | 32'(start_off * 2) | 32'($urandom_range(0, 1)));
        h_next = start_off;
        pushed = 0;
        e = 0;
        cyc = 0;
        while (e < exp_q.size() && cyc < 5000) begin
            in_valid  = (pushed < words.size()) && ($urandom_range(0, 3) != 0);
            in_rdata  = (pushed < words.size()) ? words[pushed] : 32'h0;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            held = pushed - h_next / 2;
            exp_valid = (exp_q[e].h + (exp_q[e].comp ? 1 : 2)) <= 2 * pushed;
            chk("rnd_ready", in_ready, (held < int'(Depth)) ? 1 : 0);
            chk("rnd_valid", out_valid, exp_valid ? 1 : 0);
            if (exp_valid && out_ready) begin
                if (!exp_q[e].ill) chk("rnd_instr", out_instr, exp_q[e].instr);
                chk("rnd_raw", out_raw, exp_q[e].raw);
                chk("rnd_pc", out_pc, exp_q[e].pc);
                chk("rnd_comp", out_comp, exp_q[e].comp);
                chk("rnd_ill", out_ill, exp_q[e].ill);
                chk("rnd_err", out_err, 0);
                $display("txn rnd#%0d pc=%h instr=%h c=%0d ill=%0d", e, out_pc, out_instr, out_comp, out_ill);
                h_next = exp_q[e].h + (exp_q[e].comp ? 1 : 2);
                e++;
            end
            if (in_valid && held < int'(Depth)) pushed++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("rnd_drained", 32'(e), 32'(exp_q.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
